// File: rtl/fir_filter_mc.sv
// Multi-channel FIR filter: per-channel circular history, shared run-time
// writable coefficient RAM and a single time-shared multiply-accumulate.
module fir_filter_mc #(
  parameter int unsigned IN_WIDTH   = 12,
  parameter bit          SIGNED_IN  = 1'b0,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned TAPS_LOG2  = 9,
  parameter int unsigned CH_LOG2    = 1,
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned OUT_SHIFT  = 0,
  parameter string       COEF_INIT  = ""
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  in_valid,
  input  logic [CH_LOG2-1:0]    in_ch,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  input  logic                  coef_we,
  input  logic [TAPS_LOG2-1:0]  coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  out_valid,
  output logic [CH_LOG2-1:0]    out_ch,
  output logic [ACC_WIDTH-1:0]  out_data
);

  localparam int unsigned TAPS       = 32'(1) << TAPS_LOG2;
  localparam int unsigned CHANNELS   = 32'(1) << CH_LOG2;
  localparam int unsigned HIST_AW    = CH_LOG2 + TAPS_LOG2;
  localparam int unsigned HIST_DEPTH = 32'(1) << HIST_AW;
  localparam int unsigned PROD_WIDTH = IN_WIDTH + COEF_WIDTH;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                        state;
  logic [HIST_AW-1:0]            clr_cnt;
  logic [TAPS_LOG2-1:0]          wr_ptr [CHANNELS];
  logic [CH_LOG2-1:0]            ch_q;
  logic signed [IN_WIDTH-1:0]    samp_q;
  logic [TAPS_LOG2-1:0]          base_ptr;
  logic [TAPS_LOG2-1:0]          tap;

  logic signed [IN_WIDTH-1:0]    hist_mem [HIST_DEPTH];
  logic signed [COEF_WIDTH-1:0]  coef_mem [TAPS];
  logic signed [IN_WIDTH-1:0]    hist_rd;
  logic signed [COEF_WIDTH-1:0]  coef_rd;

  logic                          rd_vld;
  logic                          rd_first;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic                          prod_vld;
  logic                          prod_first;
  logic signed [ACC_WIDTH-1:0]   acc;

  logic                          accept_c;
  logic                          coef_wen_c;
  logic signed [IN_WIDTH-1:0]    conv_c;
  logic [TAPS_LOG2-1:0]          next_ptr_c;
  logic [TAPS_LOG2-1:0]          tap_addr_c;
  logic                          hist_we_c;
  logic [HIST_AW-1:0]            hist_waddr_c;
  logic signed [IN_WIDTH-1:0]    hist_wdata_c;
  logic [HIST_AW-1:0]            hist_raddr_c;
  logic signed [ACC_WIDTH-1:0]   prod_ext_c;
  logic signed [ACC_WIDTH-1:0]   acc_sum_c;

  // Handshake, sample conversion, RAM addressing and accumulate datapath
  always_comb begin
    accept_c     = (state == S_IDLE) && in_valid && in_ready;
    coef_wen_c   = coef_we && (state == S_IDLE) && !accept_c;
    conv_c       = SIGNED_IN ? in_data : {~in_data[IN_WIDTH-1], in_data[IN_WIDTH-2:0]};
    next_ptr_c   = wr_ptr[ch_q] + TAPS_LOG2'(1);
    tap_addr_c   = base_ptr - tap;
    hist_we_c    = (state == S_CLEAR) || (state == S_WRITE);
    hist_waddr_c = (state == S_CLEAR) ? clr_cnt : {ch_q, next_ptr_c};
    hist_wdata_c = (state == S_CLEAR) ? '0 : samp_q;
    hist_raddr_c = {ch_q, tap_addr_c};
    prod_ext_c   = ACC_WIDTH'(prod);
    acc_sum_c    = prod_first ? prod_ext_c : acc + prod_ext_c;
  end

  // History and coefficient RAMs with registered read ports
  always_ff @(posedge clk) begin
    if (hist_we_c) hist_mem[hist_waddr_c] <= hist_wdata_c;
    if (coef_wen_c) coef_mem[coef_addr] <= coef_data;
    hist_rd <= hist_mem[hist_raddr_c];
    coef_rd <= coef_mem[tap];
  end

  // Control FSM plus product/accumulate pipeline
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) wr_ptr[i] <= '0;
      ch_q       <= '0;
      samp_q     <= '0;
      base_ptr   <= '0;
      tap        <= '0;
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      prod       <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      acc        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      out_valid  <= 1'b0;
      rd_vld     <= (state == S_MAC);
      rd_first   <= (state == S_MAC) && (tap == '0);
      prod_vld   <= rd_vld;
      prod_first <= rd_first;
      if (rd_vld) prod <= PROD_WIDTH'(hist_rd) * PROD_WIDTH'(coef_rd);
      if (prod_vld) acc <= acc_sum_c;

      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + HIST_AW'(1);
          if (clr_cnt == '1) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept_c) begin
            ch_q     <= in_ch;
            samp_q   <= conv_c;
            in_ready <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_ptr[ch_q] <= next_ptr_c;
          base_ptr     <= next_ptr_c;
          tap          <= '0;
          state        <= S_MAC;
        end
        S_MAC: begin
          tap <= tap + TAPS_LOG2'(1);
          if (tap == '1) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_OUT;
        // Last product is folded in on this edge so the result lands with out_valid
        S_OUT: begin
          out_valid <= 1'b1;
          out_ch    <= ch_q;
          out_data  <= ACC_WIDTH'(acc_sum_c >>> OUT_SHIFT);
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Randomised self-checking bench for fir_filter_mc (8 taps, 2 channels)
// against a shift-register convolution model.
module tb_fir_filter_mc;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned CW    = 16;
  localparam int unsigned TL2   = 3;
  localparam int unsigned CL2   = 1;
  localparam int unsigned AW    = 48;
  localparam int unsigned SHIFT = 0;
  localparam int TAPS = 1 << TL2;
  localparam int CHN  = 1 << CL2;

  logic            clk;
  logic            nreset;
  logic            in_valid;
  logic [CL2-1:0]  in_ch;
  logic [IN_W-1:0] in_data;
  logic            in_ready;
  logic            coef_we;
  logic [TL2-1:0]  coef_addr;
  logic [CW-1:0]   coef_data;
  logic            out_valid;
  logic [CL2-1:0]  out_ch;
  logic [AW-1:0]   out_data;

  fir_filter_mc #(
    .IN_WIDTH(IN_W), .SIGNED_IN(1'b0), .COEF_WIDTH(CW), .TAPS_LOG2(TL2),
    .CH_LOG2(CL2), .ACC_WIDTH(AW), .OUT_SHIFT(SHIFT), .COEF_INIT("")
  ) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .in_ready(in_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: hist_m[ch][k] is x[n-k] for that channel
  int     hist_m [CHN][TAPS];
  int     coef_m [TAPS];
  longint acc_cyc;
  longint exp_y;
  int     exp_ch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint model_y(input int ch);
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(coef_m[k]) * longint'(hist_m[ch][k]);
    return s >>> SHIFT;
  endfunction

  task automatic model_push(input int ch, input logic [IN_W-1:0] d);
    for (int k = TAPS - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
    hist_m[ch][0] = int'(d) - (1 << (IN_W - 1));
  endtask

  task automatic model_clear();
    for (int c = 0; c < CHN; c++)
      for (int k = 0; k < TAPS; k++) hist_m[c][k] = 0;
  endtask

  // One coefficient write strobe; upd says whether the DUT should honour it
  task automatic write_coef(input int a, input int v, input bit upd);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = TL2'(a);
    coef_data = CW'(v);
    @(negedge clk);
    coef_we = 1'b0;
    if (upd) coef_m[a] = int'($signed(CW'(v)));
  endtask

  // Present a sample (optionally with a coefficient write on the same edge) until accepted
  task automatic offer(input int ch, input logic [IN_W-1:0] d,
                       input bit wc, input int ca, input int cv);
    int budget = 4 * TAPS + 16;
    @(negedge clk);
    in_valid  = 1'b1;
    in_ch     = CL2'(ch);
    in_data   = d;
    coef_we   = wc;
    coef_addr = TL2'(ca);
    coef_data = CW'(cv);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(ch, d);
    exp_y  = model_y(ch);
    exp_ch = ch;
    @(negedge clk);
    acc_cyc  = cyc_cnt;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int budget = 4 * TAPS + 16;
    logic [AW-1:0] e48;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    e48 = AW'(exp_y);
    // Latency counted from the acceptance cycle to the out_valid cycle
    check({tag, "_lat"}, 64'(cyc_cnt - acc_cyc + 1), 64'(TAPS + 4));
    check({tag, "_data"}, 64'(out_data), 64'(e48));
    check({tag, "_ch"}, 64'(out_ch), 64'(exp_ch));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(out_valid), 64'd0);
  endtask

  task automatic do_sample(input int ch, input logic [IN_W-1:0] d, input string tag);
    offer(ch, d, 1'b0, 0, 0);
    wait_result(tag);
  endtask

  // Count cycles with in_ready low after reset release; out_valid must stay low
  task automatic measure_clear(input string tag);
    int cnt = 0;
    int ov  = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) ov++;
    end while (!in_ready && cnt < 200);
    check({tag, "_len"}, 64'(cnt), 64'(CHN * TAPS));
    check({tag, "_novalid"}, 64'(ov), 64'd0);
  endtask

  // Hold in_valid high for n samples; checks spacing of acceptances and each result
  task automatic stream(input int ch, input int n);
    longint        last = -1;
    int            acc_n = 0;
    int            budget = n * (TAPS + 4) + 4 * TAPS + 32;
    longint        q_y[$];
    logic [AW-1:0] e48;
    logic [IN_W-1:0] d;
    bit            take;
    @(negedge clk);
    d        = IN_W'($urandom);
    in_valid = 1'b1;
    in_ch    = CL2'(ch);
    in_data  = d;
    while ((acc_n < n || q_y.size() > 0) && budget > 0) begin
      if (out_valid) begin
        if (q_y.size() == 0) check("stream_spurious", 64'(out_valid), 64'd0);
        else begin
          e48 = AW'(q_y.pop_front());
          check("stream_data", 64'(out_data), 64'(e48));
          check("stream_ch", 64'(out_ch), 64'(ch));
        end
      end
      take = in_valid && in_ready;
      @(negedge clk);
      if (take) begin
        model_push(ch, d);
        q_y.push_back(model_y(ch));
        if (last >= 0) check("stream_gap", 64'(cyc_cnt - last), 64'(TAPS + 4));
        last = cyc_cnt;
        acc_n++;
        if (acc_n == n) in_valid = 1'b0;
        else begin
          d       = IN_W'($urandom);
          in_data = d;
        end
      end
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) check("stream_timeout", 64'(q_y.size()), 64'd0);
  endtask

  task automatic impulse(input string tag);
    do_sample(0, 12'hFFF, tag);
    for (int i = 0; i < 7; i++) do_sample(0, 12'h800, tag);
    do_sample(0, 12'h800, {tag, "_tail"});
  endtask

  initial begin
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_clear();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_ch", 64'(out_ch), 64'd0);
    nreset = 1'b1;
    measure_clear("clr");

    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, 1'b1);
    impulse("imp");

    for (int i = 0; i < TAPS; i++) begin
      do_sample(0, (i == 0) ? 12'hFFF : 12'h800, "iso0");
      do_sample(1, 12'h801, "iso1");
    end

    write_coef(0, 1, 1'b1);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0, 1'b1);
    do_sample(1, 12'h000, "conv_min");
    do_sample(1, 12'h800, "conv_mid");
    do_sample(1, 12'hFFF, "conv_max");

    // Coefficient writes during MAC or on an accepting edge must be dropped
    offer(0, 12'h123, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    write_coef(0, 777, 1'b0);
    wait_result("guard_mac");
    do_sample(0, 12'h456, "guard_mac_after");
    offer(0, 12'h234, 1'b1, 0, 999);
    wait_result("guard_same");
    do_sample(0, 12'h345, "guard_same_after");
    write_coef(0, 5, 1'b1);
    do_sample(0, 12'h700, "guard_idle");

    stream(1, 4);

    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 65535)), 1'b1);
    for (int i = 0; i < 24; i++)
      do_sample(int'($urandom_range(0, CHN - 1)), IN_W'($urandom), "rnd");

    // Reset during MAC: no result, history wiped, coefficients retained
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, 1'b1);
    offer(0, 12'hFFF, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
    end
    check("midrst_ready", 64'(in_ready), 64'd0);
    nreset = 1'b1;
    measure_clear("midrst_clr");
    model_clear();
    impulse("imp2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
